gate_guard: RTL

GATE_GUARD -- requirements
Module: gate_guard

---
 rtl/gate_guard.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/gate_guard.sv
// gate_guard: gate-drive supervisor with illegal-command and short-circuit trips.
// Per-bit minimum dwell is compiled in when GATE_GUARD_MIN_DWELL_EN is defined.
module gate_guard #(
  parameter int unsigned MIN_DWELL  = 4,
  parameter int unsigned SHORT_FILT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Sin,
  input  logic       short_in,
  input  logic       fault_clr,
  output logic [5:0] Gout,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       armed
);

  localparam int unsigned NB = 6;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] FILT_MAX   = CW'(SHORT_FILT);
  localparam logic [1:0]    CODE_NONE  = 2'b00;
  localparam logic [1:0]    CODE_SHORT = 2'b01;
  localparam logic [1:0]    CODE_ILL   = 2'b10;

  if ((MIN_DWELL < 1) || (MIN_DWELL > 15) || (SHORT_FILT < 1) || (SHORT_FILT > 15)) begin : g_param_err
    $error("gate_guard: MIN_DWELL and SHORT_FILT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] filt_q, filt_d;
  logic [NB-1:0] gout_q, gout_d;
  logic [1:0]    code_q, code_d;
  logic          fault_q, armed_q;
  logic [2:0]    pair_on_c;
  logic          illegal_c, trip_c, sin_zero_c;
  logic [NB-1:0] run_gout_c;

  // Command decode: a pair with both switches on is a shoot-through; two at once is illegal
  assign pair_on_c  = {&Sin[5:4], &Sin[3:2], &Sin[1:0]};
  assign illegal_c  = (pair_on_c[2] & pair_on_c[1]) | (pair_on_c[2] & pair_on_c[0]) |
                      (pair_on_c[1] & pair_on_c[0]);
  assign sin_zero_c = (Sin == '0);

  // Trip on the edge where the filter count would reach the threshold
  assign trip_c = sync2_q && (filt_q >= (FILT_MAX - CW'(1)));

  always_comb begin
    filt_d = filt_q;
    if (!sync2_q) begin
      filt_d = '0;
    end else if (filt_q < FILT_MAX) begin
      filt_d = filt_q + CW'(1);
    end
  end

  // Supervisor FSM; a short outranks an illegal command
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (trip_c) begin
          state_d = FAULT;
          code_d  = CODE_SHORT;
        end else if (illegal_c) begin
          state_d = FAULT;
          code_d  = CODE_ILL;
        end else if (sin_zero_c) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (trip_c) begin
          state_d = FAULT;
          code_d  = CODE_SHORT;
        end else if (illegal_c) begin
          state_d = FAULT;
          code_d  = CODE_ILL;
        end
      end
      FAULT: begin
        if (fault_clr && !sync2_q && sin_zero_c) begin
          state_d = IDLE;
          code_d  = CODE_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = CODE_NONE;
      end
    endcase
  end

`ifdef GATE_GUARD_MIN_DWELL_EN
  localparam logic [CW-1:0] DWELL_LOAD = CW'(MIN_DWELL - 1);

  logic [CW-1:0] dwell_q [NB];
  logic [CW-1:0] dwell_d [NB];

  // A bit may only move once its hold counter has run out
  always_comb begin
    run_gout_c = gout_q;
    for (int i = 0; i < NB; i++) begin
      dwell_d[i] = dwell_q[i];
      if (state_d == FAULT) begin
        dwell_d[i] = '0;
      end else if (state_q == RUN) begin
        if (dwell_q[i] != '0) begin
          dwell_d[i] = dwell_q[i] - CW'(1);
        end else if (Sin[i] != gout_q[i]) begin
          run_gout_c[i] = Sin[i];
          dwell_d[i]    = DWELL_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        dwell_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        dwell_q[i] <= dwell_d[i];
      end
    end
  end
`else
  assign run_gout_c = Sin;
`endif

  // Gates are driven only while staying in RUN
  always_comb begin
    gout_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      gout_d = run_gout_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= '0;
      gout_q  <= '0;
      code_q  <= CODE_NONE;
      fault_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= short_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      gout_q  <= gout_d;
      code_q  <= code_d;
      fault_q <= (state_d == FAULT);
      armed_q <= (state_d == RUN);
    end
  end

  assign Gout       = gout_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign armed      = armed_q;

endmodule
